// File: rtl/fpu_issue_sched.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fpu_issue_sched : FPU issue scheduler with result-edge reservation  (rev 1.0)
// -----------------------------------------------------------------------------
module fpu_issue_sched #(
  parameter int LAT_ADD   = 6,
  parameter int LAT_SUB   = 6,
  parameter int LAT_MUL   = 6,
  parameter int LAT_DIV   = 12,
  parameter int LAT_SQRT  = 6,
  parameter int LAT_FTOI  = 2,
  parameter int LAT_ITOF  = 4,
  parameter int LAT_FABS  = 2,
  parameter int ISSUE_GAP = 2,
  parameter int TAG_W     = 5,
  parameter int MAX_LAT   = 16
) (
  input  logic             mem_clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [7:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [31:0]      req_x1,
  input  logic [31:0]      req_x2,
  output logic [7:0]       fpu_opcode,
  output logic [31:0]      fpu_x1,
  output logic [31:0]      fpu_x2,
  input  logic [31:0]      fpu_y,
  input  logic             fpu_valid,
  input  logic             fpu_ovf,
  input  logic             fpu_unf,
  output logic             wb_valid,
  output logic [TAG_W-1:0] wb_tag,
  output logic [31:0]      wb_data,
  output logic [1:0]       wb_exc,
  output logic             wb_err,
  output logic             err_illegal,
  output logic             err_spurious,
  output logic [4:0]       inflight,
  output logic             idle
);

  localparam int IDX_W = $clog2(MAX_LAT + 1);
  localparam int GAP_W = $clog2(ISSUE_GAP + 1);

  // Slot 0 is the upcoming edge; slot MAX_LAT is never written and always reads free.
  logic [MAX_LAT:0] r_slot_v;
  logic [TAG_W-1:0] r_slot_tag [MAX_LAT+1];
  logic [GAP_W-1:0] r_gap;
  logic [IDX_W-1:0] r_quiet;

  logic [IDX_W-1:0] w_lat;
  logic             w_onehot;
  logic             w_slot_busy;
  logic             w_accept;
  logic             w_issue;
  logic             w_sample;

  assign w_onehot = (req_op != 8'd0) && ((req_op & (req_op - 8'd1)) == 8'd0);

  always_comb begin
    w_lat = '0;
    case (req_op)
      8'h01:   w_lat = IDX_W'(LAT_ADD);
      8'h02:   w_lat = IDX_W'(LAT_SUB);
      8'h04:   w_lat = IDX_W'(LAT_MUL);
      8'h08:   w_lat = IDX_W'(LAT_DIV);
      8'h10:   w_lat = IDX_W'(LAT_SQRT);
      8'h20:   w_lat = IDX_W'(LAT_FTOI);
      8'h40:   w_lat = IDX_W'(LAT_ITOF);
      8'h80:   w_lat = IDX_W'(LAT_FABS);
      default: w_lat = '0;
    endcase
  end

  // The sampling edge k+1+L sits one slot further out before this edge's shift.
  assign w_slot_busy = r_slot_v[w_lat + IDX_W'(1)];
  assign req_ready   = rstn && (!w_onehot || ((r_gap == '0) && !w_slot_busy));
  assign w_accept    = req_valid && req_ready;
  assign w_issue     = w_accept && w_onehot;
  assign w_sample    = r_slot_v[0];
  assign idle        = rstn && (inflight == 5'd0) && (r_gap == '0);

  always_ff @(posedge mem_clk) begin
    if (!rstn) begin
      r_slot_v <= '0;
      for (int i = 0; i <= MAX_LAT; i++) begin
        r_slot_tag[i] <= '0;
      end
    end else begin
      r_slot_v <= {1'b0, r_slot_v[MAX_LAT:1]};
      for (int i = 0; i < MAX_LAT; i++) begin
        r_slot_tag[i] <= r_slot_tag[i+1];
      end
      r_slot_tag[MAX_LAT] <= '0;
      if (w_issue) begin
        r_slot_v[w_lat]   <= 1'b1;
        r_slot_tag[w_lat] <= req_tag;
      end
    end
  end

  always_ff @(posedge mem_clk) begin
    if (!rstn) begin
      r_gap      <= '0;
      r_quiet    <= IDX_W'(MAX_LAT);
      fpu_opcode <= '0;
      fpu_x1     <= '0;
      fpu_x2     <= '0;
    end else begin
      fpu_opcode <= w_issue ? req_op : 8'd0;
      if (w_issue) begin
        fpu_x1 <= req_x1;
        fpu_x2 <= req_x2;
        r_gap  <= GAP_W'(ISSUE_GAP - 1);
      end else if (r_gap != '0) begin
        r_gap <= r_gap - GAP_W'(1);
      end
      if (r_quiet != '0) begin
        r_quiet <= r_quiet - IDX_W'(1);
      end
    end
  end

  always_ff @(posedge mem_clk) begin
    if (!rstn) begin
      wb_valid     <= 1'b0;
      wb_tag       <= '0;
      wb_data      <= '0;
      wb_exc       <= '0;
      wb_err       <= 1'b0;
      err_illegal  <= 1'b0;
      err_spurious <= 1'b0;
      inflight     <= '0;
    end else begin
      wb_valid <= w_sample;
      wb_err   <= 1'b0;
      if (w_sample) begin
        wb_tag  <= r_slot_tag[0];
        wb_data <= fpu_y;
        wb_exc  <= {fpu_ovf, fpu_unf};
        wb_err  <= ~fpu_valid;
      end else if (fpu_valid && (r_quiet == '0)) begin
        err_spurious <= 1'b1;
      end
      if (w_accept && !w_onehot) begin
        err_illegal <= 1'b1;
      end
      if (w_issue && !w_sample && (inflight != 5'd31)) begin
        inflight <= inflight + 5'd1;
      end else if (!w_issue && w_sample && (inflight != 5'd0)) begin
        inflight <= inflight - 5'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_sched.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for fpu_issue_sched: latency table, corner sequences, random traffic against an
// edge-indexed reservation model.
module tb_fpu_issue_sched;

  localparam int TAG_W   = 5;
  localparam int MAX_LAT = 16;
  localparam int GAP     = 2;

  logic             mem_clk = 1'b0;
  logic             rstn;
  logic             req_valid;
  logic             req_ready;
  logic [7:0]       req_op;
  logic [TAG_W-1:0] req_tag;
  logic [31:0]      req_x1, req_x2;
  logic [7:0]       fpu_opcode;
  logic [31:0]      fpu_x1, fpu_x2, fpu_y;
  logic             fpu_valid, fpu_ovf, fpu_unf;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [31:0]      wb_data;
  logic [1:0]       wb_exc;
  logic             wb_err, err_illegal, err_spurious;
  logic [4:0]       inflight;
  logic             idle;

  fpu_issue_sched dut (
    .mem_clk(mem_clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_tag(req_tag),
    .req_x1(req_x1), .req_x2(req_x2),
    .fpu_opcode(fpu_opcode), .fpu_x1(fpu_x1), .fpu_x2(fpu_x2),
    .fpu_y(fpu_y), .fpu_valid(fpu_valid), .fpu_ovf(fpu_ovf), .fpu_unf(fpu_unf),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .wb_exc(wb_exc), .wb_err(wb_err),
    .err_illegal(err_illegal), .err_spurious(err_spurious), .inflight(inflight), .idle(idle)
  );

  always #5 mem_clk = ~mem_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int m_lat [8] = '{6, 6, 6, 12, 6, 2, 4, 2};

  // Model: absolute sampling edge -> tag of the op reserved there.
  logic [TAG_W-1:0] m_resv [int];
  int               m_last_issue = -100;
  int               m_rst_edge   = 0;

  logic [7:0]       e_opcode;
  logic [31:0]      e_x1, e_x2, e_data;
  logic [TAG_W-1:0] e_tag;
  logic [1:0]       e_exc;
  logic             e_wbv, e_err, e_ill, e_spur;
  int               e_inflight;

  // Bench FPU: results it will return per edge; unaffected by scheduler reset.
  typedef struct packed { logic [31:0] y; logic ovf; logic unf; } res_t;
  res_t        fpu_sched [int];
  logic [31:0] plan_y     = '0;
  logic [1:0]  plan_exc   = '0;
  logic        plan_miss  = 1'b0;
  logic        force_spur = 1'b0;

  typedef struct {
    logic [7:0]       op;
    logic [TAG_W-1:0] tag;
    logic [31:0]      x1, x2, y;
    logic [1:0]       exc;
    int               lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic int lat_of(input logic [7:0] op);
    lat_of = 0;
    for (int i = 0; i < 8; i++) if (op[i]) lat_of = m_lat[i];
  endfunction

  task automatic drive(input logic v, input logic [7:0] op, input logic [TAG_W-1:0] tag,
                       input logic [31:0] a, input logic [31:0] b);
    req_valid = v; req_op = op; req_tag = tag; req_x1 = a; req_x2 = b;
  endtask

  task automatic nop();
    drive(1'b0, 8'h00, '0, 32'h0, 32'h0);
  endtask

  // Advance across edge number cyc, checking ready before it and all registers after it.
  task automatic step();
    int   e, lat;
    bit   oh;
    logic rdy;
    if (fpu_sched.exists(cyc)) begin
      fpu_valid = 1'b1;
      {fpu_y, fpu_ovf, fpu_unf} = fpu_sched[cyc];
      fpu_sched.delete(cyc);
    end else begin
      fpu_valid = force_spur;
      fpu_y = $urandom;
      {fpu_ovf, fpu_unf} = 2'($urandom);
    end
    force_spur = 1'b0;
    @(negedge mem_clk);
    e = cyc;
    if (!rstn) begin
      chk("ready_in_reset", req_ready, 0);
      m_resv.delete();
      m_last_issue = -100;
      m_rst_edge = e;
      e_opcode = '0; e_x1 = '0; e_x2 = '0; e_data = '0; e_tag = '0; e_exc = '0;
      e_wbv = 0; e_err = 0; e_ill = 0; e_spur = 0; e_inflight = 0;
    end else begin
      oh  = ($countones(req_op) == 1);
      lat = lat_of(req_op);
      rdy = oh ? ((e - m_last_issue >= GAP) && !m_resv.exists(e + 1 + lat)) : 1'b1;
      chk("req_ready", req_ready, rdy);
      e_opcode = '0;
      e_wbv = 1'b0;
      if (m_resv.exists(e)) begin
        e_wbv = 1'b1; e_tag = m_resv[e]; e_data = fpu_y;
        e_exc = {fpu_ovf, fpu_unf}; e_err = !fpu_valid;
        m_resv.delete(e);
      end else if (fpu_valid && (e > m_rst_edge + MAX_LAT)) begin
        e_spur = 1'b1;
      end
      if (req_valid && rdy) begin
        if (oh) begin
          m_resv[e + 1 + lat] = req_tag;
          e_opcode = req_op; e_x1 = req_x1; e_x2 = req_x2;
          m_last_issue = e;
          if (!plan_miss) fpu_sched[e + 1 + lat] = {plan_y, plan_exc};
        end else begin
          e_ill = 1'b1;
        end
      end
      e_inflight = m_resv.num();
    end
    @(posedge mem_clk);
    cyc++;
    #1;
    chk("fpu_opcode", fpu_opcode, e_opcode);
    chk("fpu_x1", fpu_x1, e_x1);
    chk("fpu_x2", fpu_x2, e_x2);
    chk("wb_valid", wb_valid, e_wbv);
    chk("wb_tag", wb_tag, e_tag);
    chk("wb_data", wb_data, e_data);
    if (e_wbv) begin
      chk("wb_exc", wb_exc, e_exc);
      chk("wb_err", wb_err, e_err);
    end
    chk("err_illegal", err_illegal, e_ill);
    chk("err_spurious", err_spurious, e_spur);
    chk("inflight", inflight, e_inflight);
    chk("idle", idle, rstn && (e_inflight == 0) && (cyc - m_last_issue >= GAP));
  endtask

  task automatic run_to(input int target);
    nop();
    while (cyc < target) step();
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    nop();
    while ((m_resv.num() != 0 || cyc - m_last_issue < GAP) && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) chk("quiet_timeout", n, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [8];
    int   k, n, wbcnt;
    logic [7:0] op;

    vt[0] = '{8'h01, 5'd1, 32'h3F800000, 32'h40000000, 32'h40400000, 2'b00, 6};
    vt[1] = '{8'h02, 5'd2, 32'h40400000, 32'h3F800000, 32'h40000000, 2'b00, 6};
    vt[2] = '{8'h04, 5'd3, 32'h40000000, 32'h40400000, 32'h40C00000, 2'b00, 6};
    vt[3] = '{8'h08, 5'd4, 32'h40C00000, 32'h40000000, 32'h40400000, 2'b01, 12};
    vt[4] = '{8'h10, 5'd5, 32'h41100000, 32'h00000000, 32'h40400000, 2'b00, 6};
    vt[5] = '{8'h20, 5'd6, 32'h40490FDB, 32'h00000000, 32'h00000003, 2'b00, 2};
    vt[6] = '{8'h40, 5'd7, 32'h00000007, 32'h00000000, 32'h40E00000, 2'b00, 4};
    vt[7] = '{8'h80, 5'd8, 32'hBF800000, 32'h00000000, 32'h3F800000, 2'b10, 2};

    rstn = 1'b0;
    fpu_valid = 1'b0; fpu_y = '0; fpu_ovf = 1'b0; fpu_unf = 1'b0;
    nop();
    repeat (3) step();
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_opcode", fpu_opcode, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_idle", idle, 0);
    rstn = 1'b1;
    #1 chk("idle_after_rst", idle, 1);

    // fadd accepted at edge 10, result sampled at edge 17
    run_to(10);
    plan_y = 32'h40400000;
    drive(1'b1, 8'h01, 5'd3, 32'h3F800000, 32'h40000000);
    step();
    chk("fadd_opcode", fpu_opcode, 8'h01);
    run_to(17);
    chk("fadd_early_wb", wb_valid, 0);
    step();
    chk("fadd_wb_valid", wb_valid, 1);
    chk("fadd_wb_tag", wb_tag, 3);
    chk("fadd_wb_data", wb_data, 32'h40400000);
    chk("fadd_wb_err", wb_err, 0);
    step();
    chk("fadd_wb_pulse", wb_valid, 0);

    // per-op latency table
    for (int i = 0; i < 8; i++) begin
      wait_quiet();
      plan_y = vt[i].y; plan_exc = vt[i].exc;
      drive(1'b1, vt[i].op, vt[i].tag, vt[i].x1, vt[i].x2);
      step();
      chk("vec_opcode", fpu_opcode, vt[i].op);
      chk("vec_x1", fpu_x1, vt[i].x1);
      chk("vec_x2", fpu_x2, vt[i].x2);
      nop();
      n = 0;
      while (!wb_valid && n < 20) begin step(); n++; end
      chk("vec_latency", n, vt[i].lat + 1);
      chk("vec_tag", wb_tag, vt[i].tag);
      chk("vec_data", wb_data, vt[i].y);
      chk("vec_exc", wb_exc, vt[i].exc);
    end
    plan_exc = 2'b00;

    // result-slot conflict: fdiv at k reserves k+13, fmul at k+6 would collide
    wait_quiet();
    k = cyc;
    drive(1'b1, 8'h08, 5'd7, 32'h1, 32'h2);
    step();
    run_to(k + 6);
    drive(1'b1, 8'h04, 5'd9, 32'h3, 32'h4);
    #1 chk("conflict_ready", req_ready, 0);
    step();
    nop();
    step();
    drive(1'b1, 8'h04, 5'd9, 32'h3, 32'h4);
    #1 chk("fmul_ready", req_ready, 1);
    step();
    run_to(k + 13);
    step();
    chk("conflict_div_wb", wb_valid, 1);
    chk("conflict_div_tag", wb_tag, 7);
    step();
    chk("conflict_gap_wb", wb_valid, 0);
    step();
    chk("conflict_mul_wb", wb_valid, 1);
    chk("conflict_mul_tag", wb_tag, 9);

    // issue gap and out-of-order writeback
    wait_quiet();
    k = cyc;
    drive(1'b1, 8'h10, 5'd11, 32'h5, 32'h6);
    step();
    chk("gap_inflight_1", inflight, 1);
    drive(1'b1, 8'h80, 5'd12, 32'h7, 32'h8);
    #1 chk("gap_ready", req_ready, 0);
    step();
    chk("gap_not_issued", fpu_opcode, 0);
    step();
    chk("gap_fabs_issue", fpu_opcode, 8'h80);
    chk("gap_inflight_2", inflight, 2);
    run_to(k + 5);
    step();
    chk("reorder_first_tag", wb_tag, 12);
    chk("reorder_inflight_1", inflight, 1);
    step();
    step();
    chk("reorder_second_wb", wb_valid, 1);
    chk("reorder_second_tag", wb_tag, 11);
    chk("reorder_inflight_0", inflight, 0);

    // illegal op
    wait_quiet();
    drive(1'b1, 8'h03, 5'd4, 32'h9, 32'hA);
    #1 chk("ill_ready", req_ready, 1);
    step();
    chk("ill_opcode", fpu_opcode, 0);
    chk("ill_flag", err_illegal, 1);
    chk("ill_inflight", inflight, 0);
    nop();
    wbcnt = 0;
    repeat (16) begin step(); if (wb_valid) wbcnt++; end
    chk("ill_no_wb", wbcnt, 0);

    // missing result then spurious result
    wait_quiet();
    k = cyc;
    plan_miss = 1'b1;
    drive(1'b1, 8'h20, 5'd6, 32'hB, 32'hC);
    step();
    plan_miss = 1'b0;
    run_to(k + 3);
    step();
    chk("miss_wb_valid", wb_valid, 1);
    chk("miss_wb_err", wb_err, 1);
    chk("miss_wb_tag", wb_tag, 6);
    step();
    chk("spur_before", err_spurious, 0);
    force_spur = 1'b1;
    step();
    chk("spur_flag", err_spurious, 1);

    // reset with three ops in flight
    wait_quiet();
    drive(1'b1, 8'h08, 5'd13, 32'h11, 32'h12); step(); nop(); step();
    drive(1'b1, 8'h04, 5'd14, 32'h13, 32'h14); step(); nop(); step();
    drive(1'b1, 8'h10, 5'd15, 32'h15, 32'h16); step(); nop();
    chk("pre_rst_inflight", inflight, 3);
    rstn = 1'b0;
    step();
    chk("midrst_ready", req_ready, 0);
    chk("midrst_wb_valid", wb_valid, 0);
    chk("midrst_opcode", fpu_opcode, 0);
    chk("midrst_x1", fpu_x1, 0);
    chk("midrst_inflight", inflight, 0);
    chk("midrst_spur", err_spurious, 0);
    chk("midrst_ill", err_illegal, 0);
    rstn = 1'b1;
    wbcnt = 0;
    repeat (20) begin step(); if (wb_valid) wbcnt++; end
    chk("midrst_no_wb", wbcnt, 0);
    chk("midrst_no_spur", err_spurious, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rstn = (i != 300);
      if ($urandom_range(0, 99) < 45) begin
        nop();
      end else begin
        if ($urandom_range(0, 99) < 92) op = 8'h01 << $urandom_range(0, 7);
        else op = 8'($urandom);
        drive(1'b1, op, TAG_W'($urandom), $urandom, $urandom);
      end
      plan_y    = $urandom;
      plan_exc  = 2'($urandom);
      plan_miss = ($urandom_range(0, 9) == 0);
      force_spur = !m_resv.exists(cyc) && !fpu_sched.exists(cyc) && ($urandom_range(0, 49) == 0);
      step();
    end
    rstn = 1'b1;
    plan_miss = 1'b0;
    wait_quiet();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
